// File: rtl/shift_sequencer.sv
// shift_sequencer: drives a universal shift register through one
// "load, then shift n positions" operation per start request, with a
// one-cycle done pulse at the end. Outputs are Moore-decoded from the state
// and the operands captured at start.
//
// Optional build macro SHIFT_SEQUENCER_ROTATE_EN adds a rot input; when the
// captured rot is set, the serial fill comes from the register's own end bit
// (q), which turns the shift into a rotate by n.
module shift_sequencer #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          ck,
  input  logic          cl,
  input  logic          start,
  input  logic          dir,
  input  logic [CW-1:0] n,
  input  logic [W-1:0]  d,
  input  logic          sin,
`ifdef SHIFT_SEQUENCER_ROTATE_EN
  input  logic          rot,
`endif
  input  logic [W-1:0]  q,
  output logic          load,
  output logic          shr,
  output logic          shl,
  output logic          xr,
  output logic          xl,
  output logic [W-1:0]  x,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic [W-1:0]  d_reg;
  logic          dir_reg;
  logic [CW-1:0] n_reg;
  logic          sin_reg;
  logic          capture;

`ifdef SHIFT_SEQUENCER_ROTATE_EN
  logic          rot_reg;
`else
  // q only feeds the rotate path; fold it into a sink so it stays connected.
  logic          unused_q;
  assign unused_q = ^q;
`endif

  // Next-state and shift-count logic.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (n_reg == '0) begin
          state_next = DONE;
        end else begin
          count_next = n_reg;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        count_next = count_reg - 1'b1;
        if (count_reg == CW'(1)) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counter and operand capture; cl wins over everything.
  always_ff @(posedge ck) begin
    if (cl) begin
      state_reg <= IDLE;
      count_reg <= '0;
      d_reg     <= '0;
      dir_reg   <= 1'b0;
      n_reg     <= '0;
      sin_reg   <= 1'b0;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
      rot_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (capture) begin
        d_reg   <= d;
        dir_reg <= dir;
        n_reg   <= n;
        sin_reg <= sin;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
        rot_reg <= rot;
`endif
      end
    end
  end

  // Moore output decode; only one of load/shr/shl can ever be high.
  always_comb begin
    load = 1'b0;
    shr  = 1'b0;
    shl  = 1'b0;
    xr   = 1'b0;
    xl   = 1'b0;
    x    = '0;
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      LOAD: begin
        load = 1'b1;
        x    = d_reg;
        busy = 1'b1;
      end
      SHIFT: begin
        busy = 1'b1;
        shr  = ~dir_reg;
        shl  = dir_reg;
        x    = d_reg;
        xr   = sin_reg;
        xl   = sin_reg;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
        if (rot_reg) begin
          xr = q[0];
          xl = q[W-1];
        end
`endif
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Testbench for shift_sequencer: a behavioural universal shift register
// closes the loop on q; table vectors cover single operations and a few
// hand-written sequences cover back-to-back starts and an abort by cl.
module tb_shift_sequencer;

  logic       ck = 1'b0;
  logic       cl, start, dir, sin, rot;
  logic [3:0] n;
  logic [7:0] d;
  logic [7:0] q = 8'h00;
  logic       load, shr, shl, xr, xl, busy, done;
  logic [7:0] x;

  int pass_cnt  = 0;
  int check_cnt = 0;

  always #5 ck = ~ck;

  shift_sequencer #(.W(8), .CW(4)) dut (
    .ck(ck), .cl(cl), .start(start), .dir(dir), .n(n), .d(d), .sin(sin),
`ifdef SHIFT_SEQUENCER_ROTATE_EN
    .rot(rot),
`endif
    .q(q), .load(load), .shr(shr), .shl(shl), .xr(xr), .xl(xl), .x(x),
    .busy(busy), .done(done)
  );

  // Controlled register model (not touched by cl).
  always @(posedge ck) begin
    if (load)     q <= x;
    else if (shr) q <= {xr, q[7:1]};
    else if (shl) q <= {q[6:0], xl};
  end

  typedef struct {
    logic [7:0] d;
    logic       dir;
    logic       sin;
    logic       rot;
    logic [3:0] n;
    logic [7:0] exp_q;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    check_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One full operation: drive, scramble inputs after capture, observe.
  task automatic run_op(input vec_t v, input int id);
    int loads = 0, shrs = 0, shls = 0, dones = 0, busys = 0, multi = 0;
    int done_at = -1;
    int nn;
    logic [7:0] qf;
    nn = int'(v.n);
    qf = 8'h00;
    @(negedge ck);
    d = v.d; dir = v.dir; n = v.n; sin = v.sin; rot = v.rot; start = 1'b1;
    @(posedge ck);
    #1;
    start = 1'b0; d = ~v.d; dir = ~v.dir; n = v.n + 4'd3; sin = ~v.sin; rot = ~v.rot;
    for (int i = 0; i < nn + 5; i++) begin
      @(negedge ck);
      loads += int'(load);
      shrs  += int'(shr);
      shls  += int'(shl);
      busys += int'(busy);
      if (int'(load) + int'(shr) + int'(shl) > 1) multi++;
      if (done) begin
        dones++;
        done_at = i;
      end
      if (i == nn + 1) qf = q;
    end
    check($sformatf("op%0d load_cycles", id), loads, 1);
    check($sformatf("op%0d shift_cycles", id), v.dir ? shls : shrs, nn);
    check($sformatf("op%0d wrong_dir_cycles", id), v.dir ? shrs : shls, 0);
    check($sformatf("op%0d done_cycles", id), dones, 1);
    check($sformatf("op%0d done_position", id), done_at, nn + 1);
    check($sformatf("op%0d busy_cycles", id), busys, nn + 2);
    check($sformatf("op%0d control_overlap", id), multi, 0);
    check($sformatf("op%0d q_final", id), int'(qf), int'(v.exp_q));
    $display("op %0d: d=%02h dir=%0d sin=%0d rot=%0d n=%0d -> q=%02h (want %02h)",
             id, v.d, v.dir, v.sin, v.rot, v.n, qf, v.exp_q);
  endtask

  initial begin
    int bp, loads, shrs, dones;
    logic [7:0] q_mid, q_end;

    vecs.push_back('{d: 8'b00110101, dir: 1'b0, sin: 1'b0, rot: 1'b0, n: 4'd3,  exp_q: 8'b00000110});
    vecs.push_back('{d: 8'b01010001, dir: 1'b1, sin: 1'b1, rot: 1'b0, n: 4'd4,  exp_q: 8'b00011111});
    vecs.push_back('{d: 8'hA5,       dir: 1'b0, sin: 1'b1, rot: 1'b0, n: 4'd0,  exp_q: 8'hA5});
    vecs.push_back('{d: 8'hFF,       dir: 1'b0, sin: 1'b0, rot: 1'b0, n: 4'd10, exp_q: 8'h00});
    vecs.push_back('{d: 8'h80,       dir: 1'b1, sin: 1'b1, rot: 1'b0, n: 4'd1,  exp_q: 8'h01});
    vecs.push_back('{d: 8'h00,       dir: 1'b1, sin: 1'b1, rot: 1'b0, n: 4'd15, exp_q: 8'hFF});
    vecs.push_back('{d: 8'h3C,       dir: 1'b0, sin: 1'b1, rot: 1'b0, n: 4'd2,  exp_q: 8'hCF});
`ifdef SHIFT_SEQUENCER_ROTATE_EN
    vecs.push_back('{d: 8'b00110101, dir: 1'b0, sin: 1'b0, rot: 1'b1, n: 4'd3,  exp_q: 8'b10100110});
    vecs.push_back('{d: 8'b00110101, dir: 1'b1, sin: 1'b0, rot: 1'b1, n: 4'd8,  exp_q: 8'b00110101});
`endif

    // Reset state.
    cl = 1'b1; start = 1'b1; dir = 1'b0; sin = 1'b1; rot = 1'b0; n = 4'd3; d = 8'h5A;
    repeat (2) @(posedge ck);
    @(negedge ck);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset controls", int'({load, shr, shl, xr, xl}), 0);
    check("reset x", int'(x), 0);
    cl = 1'b0; start = 1'b0;
    $display("reset: busy=%0d done=%0d x=%02h", busy, done, x);

    // Table vectors.
    foreach (vecs[k]) run_op(vecs[k], k);

    // Start held high: back-to-back operations, extra starts ignored.
    @(negedge ck);
    d = 8'hC3; dir = 1'b0; sin = 1'b1; rot = 1'b0; n = 4'd2; start = 1'b1;
    @(posedge ck);
    bp = 0; loads = 0; shrs = 0; dones = 0; q_mid = 8'h00; q_end = 8'h00;
    for (int i = 0; i < 10; i++) begin
      @(negedge ck);
      bp    |= int'(busy) << i;
      loads += int'(load);
      shrs  += int'(shr) + int'(shl);
      dones += int'(done);
      if (i == 2) d = 8'h0F;
      if (i == 4) q_mid = q;
      if (i == 9) begin
        q_end = q;
        start = 1'b0;
      end
    end
    check("b2b busy_pattern", bp, 10'b0111101111);
    check("b2b load_cycles", loads, 2);
    check("b2b shift_cycles", shrs, 4);
    check("b2b done_cycles", dones, 2);
    check("b2b q_first", int'(q_mid), 8'hF0);
    check("b2b q_second", int'(q_end), 8'hC3);
    $display("b2b: busy=%03h q1=%02h q2=%02h", bp, q_mid, q_end);

    // Abort with cl during the first shift cycle of an n=5 operation.
    repeat (2) @(negedge ck);
    d = 8'hB6; dir = 1'b0; sin = 1'b0; n = 4'd5; start = 1'b1;
    @(posedge ck);
    #1 start = 1'b0;
    @(negedge ck);                // LOAD
    @(negedge ck);                // first SHIFT cycle
    cl = 1'b1;
    @(negedge ck);
    cl = 1'b0;
    check("abort busy", int'(busy), 0);
    check("abort controls", int'({load, shr, shl, xr, xl, done}), 0);
    check("abort x", int'(x), 0);
    check("abort q", int'(q), 8'h5B);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge ck);
      dones += int'(done) + int'(busy);
    end
    check("abort no_done", dones, 0);
    check("abort q_frozen", int'(q), 8'h5B);
    $display("abort: q=%02h", q);
    run_op(vecs[0], 99);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Controller that drives the universal shift register (ports load, shr, shl, xr, xl, x) through a complete "load then shift N positions" operation.
- Handshake: one start pulse in, one done pulse out.
- Sits between a requesting unit and a uregister instance; reads the register output q back for the optional rotate mode.
- Turns the register into a self-sequenced parallel shifter or serializer.

Parameters:
- W, 8, data width; must equal the width of the controlled register.
- CW, 4, width of the shift-count input; counts 0..2^CW-1 are allowed.

Ports:
- ck  input  1  clock; all state changes on the rising edge.
- cl  input  1  synchronous active-high reset.
- start  input  1  request; sampled only in IDLE.
- dir  input  1  0 = shift right (shr), 1 = shift left (shl).
- n  input  CW  number of shift positions.
- d  input  W  data to load.
- sin  input  1  serial fill bit for the shifts.
- q  input  W  register output, read back.
- load  output  1  to register load.
- shr  output  1  to register shr.
- shl  output  1  to register shl.
- xr  output  1  to register xr.
- xl  output  1  to register xl.
- x  output  W  to register parallel input.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- One clock (ck). cl is synchronous and active-high, and has priority over everything else.
- Reset, at the next edge with cl=1:
  - state = IDLE, count = 0, captured registers = 0.
  - All outputs are 0: load, shr, shl, xr, xl, x, busy, done.
  - The reset does not act on the controlled register; q holds its value.
- Outputs are Moore: decoded from state and captured registers only.
- States are IDLE, LOAD, SHIFT, DONE.
- IDLE: all outputs 0.
  - Edge with start=1: capture d, dir, n, sin; go to LOAD.
- LOAD: load=1, x=captured d, busy=1.
  - Next edge: the register loads.
  - If captured n==0, go to DONE; otherwise count = n and go to SHIFT.
- SHIFT: busy=1; shr = ~dir_c, shl = dir_c; xr = xl = captured sin; x = captured d.
  - Each edge: count = count-1.
  - At the edge where count==1, go to DONE.
  - The register therefore shifts exactly n times.
- DONE: done=1, busy=1, all register controls 0. Next edge: go to IDLE.
- Timing, with start sampled at edge E0:
  - E1: the register loads.
  - E2..E(n+1): the register shifts.
  - done is high for exactly one cycle, between E(n+1) and E(n+2).
  - busy is high from E0 to E(n+2), i.e. n+2 cycles.
- start outside IDLE is ignored with no queueing, including during DONE. A new request is accepted from E(n+2) onward.
- At most one of load/shr/shl is high in any cycle.
- Input changes to d, n, dir, sin after capture have no effect on the operation in progress.
- n ≥ W is legal; every bit is then replaced by sin.
- cl during LOAD or SHIFT aborts the operation: IDLE, no done pulse; the register keeps its partially shifted value.

Optional Feature:
- Macro: SHIFT_SEQUENCER_ROTATE_EN.
- When defined:
  - Extra input port rot (1 bit), captured with start.
  - If captured rot=1, the serial input in SHIFT comes from q instead of sin: xr = q[0] for right shifts, xl = q[W-1] for left shifts. The operation is therefore a rotate by n.
  - If captured rot=0, behaviour is identical to the build without the macro.
- When undefined: no rot port, q is unused, xr = xl = captured sin.

Test Plan:
- d=8'b00110101, dir=0, sin=0, n=3, start for 1 cycle → load pulse at E0..E1, shr high 3 cycles, done 1 cycle after the 3rd shift; q=8'b00000110, busy back to 0.
- d=8'b01010001, dir=1, sin=1, n=4 → shl high 4 cycles; q=8'b00011111; done high exactly 1 cycle.
- n=0, d=8'hA5 → load only, no shr/shl; done between E1 and E2; q=8'hA5.
- start held high continuously, n=2 → operations are back-to-back with 1 IDLE cycle between them. start pulses during SHIFT and DONE are ignored (still 2 shifts each); q is correct after each operation.
- cl=1 at the 2nd SHIFT cycle of n=5 → all outputs 0 after that edge, no done pulse, q frozen at the value after 1 shift; the next start completes normally.
- With SHIFT_SEQUENCER_ROTATE_EN: d=8'b00110101, dir=0, rot=1, n=3 → q=8'b10100110; with dir=1, n=8 → q returns to 8'b00110101.
